// File: rtl/multicycle_ctrl_if.sv
// Datapath control bundle between multicycle_ctrl and the shared datapath.
//   master : controller side (takes instr/EQ/mem_ready, drives all controls)
//   slave  : datapath side
// Signals: instr, EQ, mem_ready (to controller); pc_write, pc_src, ir_write,
// adr_src, mem_read, MemWrite, RegWrite, alu_src_a, alu_src_b, ALUctrl,
// ImmSrc, result_src, state_o, illegal, retired (from controller).
interface multicycle_ctrl_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     instr;
  logic                 EQ;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_src;
  logic                 ir_write;
  logic                 adr_src;
  logic                 mem_read;
  logic                 MemWrite;
  logic                 RegWrite;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [2:0]           ALUctrl;
  logic [1:0]           ImmSrc;
  logic [1:0]           result_src;
  logic [3:0]           state_o;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  instr, EQ, mem_ready,
    output pc_write, pc_src, ir_write, adr_src, mem_read, MemWrite, RegWrite,
           alu_src_a, alu_src_b, ALUctrl, ImmSrc, result_src, state_o,
           illegal, retired
  );

  modport slave (
    output instr, EQ, mem_ready,
    input  pc_write, pc_src, ir_write, adr_src, mem_read, MemWrite, RegWrite,
           alu_src_a, alu_src_b, ALUctrl, ImmSrc, result_src, state_o,
           illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a shared-datapath reduced RISC-V core.
// Sequences FETCH/DECODE/execute/writeback over 3-5 cycles, drives every
// datapath enable and mux select from the current state (BRANCH also looks at
// EQ and funct3), counts retired instructions and halts in TRAP on an
// unsupported opcode or branch funct3 until reset.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (forces all enables low while high)
//   bus  - multicycle_ctrl_if.master: instr/EQ/mem_ready in, controls out
// Build option:
//   MEM_WAIT_EN - FETCH, MEMRD and MEMWR hold until mem_ready=1. Without it
//                 mem_ready is ignored and each memory state lasts one cycle.
module multicycle_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_EXECR  = 4'd5,
    S_EXECI  = 4'd6,
    S_ALUWB  = 4'd7,
    S_MEMWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t               state, nxt;
  ctrl_t                cw;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [WIDTH-1:0]     ir;
  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic                 f7b;
  logic                 mem_done;
  logic                 br_taken;
  logic                 retire_evt;

  assign ir     = bus.instr;
  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7b    = ir[30];

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
  logic unused_ok;
  assign unused_ok = ^{ir[WIDTH-1:31], ir[29:15], ir[11:7]};
`else
  assign mem_done = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{ir[WIDTH-1:31], ir[29:15], ir[11:7], bus.mem_ready};
`endif

  // funct3 -> ALU op; sub_ok selects sub on funct3=000 (R-type funct7[30] only)
  function automatic logic [2:0] alu_op(input logic [2:0] fn3, input logic sub_ok);
    case (fn3)
      3'b000:  alu_op = sub_ok ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  assign br_taken = ((f3 == 3'b000) && bus.EQ) || ((f3 == 3'b001) && !bus.EQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      retired_q <= '0;
    end else begin
      state <= nxt;
      if (retire_evt) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    cw  = '0;
    nxt = state;
    case (state)
      S_FETCH: begin
        cw.adr_src  = 1'b0;
        cw.mem_read = 1'b1;
        cw.src_a    = 2'b00;
        cw.src_b    = 2'b10;
        cw.alu_ctrl = ALU_ADD;
        // IR and PC only load once the fetched word is actually there
        cw.ir_write = mem_done;
        cw.pc_write = mem_done;
        if (mem_done) nxt = S_DECODE;
      end
      S_DECODE: begin
        // speculative branch target oldPC+immB parked in ALUout
        cw.src_a    = 2'b01;
        cw.src_b    = 2'b01;
        cw.imm_src  = 2'b10;
        cw.alu_ctrl = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:              nxt = S_EXECR;
          OP_I:              nxt = S_EXECI;
          OP_BR:             nxt = S_BRANCH;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        cw.src_a    = 2'b10;
        cw.src_b    = 2'b01;
        cw.alu_ctrl = ALU_ADD;
        cw.imm_src  = (opcode == OP_STORE) ? 2'b01 : 2'b00;
        nxt         = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        cw.adr_src  = 1'b1;
        cw.mem_read = 1'b1;
        if (mem_done) nxt = S_MEMWB;
      end
      S_MEMWR: begin
        cw.adr_src   = 1'b1;
        cw.mem_write = 1'b1;
        if (mem_done) nxt = S_FETCH;
      end
      S_EXECR: begin
        cw.src_a    = 2'b10;
        cw.src_b    = 2'b00;
        cw.alu_ctrl = alu_op(f3, f7b);
        nxt         = S_ALUWB;
      end
      S_EXECI: begin
        cw.src_a    = 2'b10;
        cw.src_b    = 2'b01;
        cw.imm_src  = 2'b00;
        cw.alu_ctrl = alu_op(f3, 1'b0);
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        cw.result_src = 2'b00;
        cw.reg_write  = 1'b1;
        nxt           = S_FETCH;
      end
      S_MEMWB: begin
        cw.result_src = 2'b01;
        cw.reg_write  = 1'b1;
        nxt           = S_FETCH;
      end
      S_BRANCH: begin
        cw.src_a    = 2'b10;
        cw.src_b    = 2'b00;
        cw.alu_ctrl = ALU_SUB;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          cw.pc_write = br_taken;
          cw.pc_src   = br_taken;
          nxt         = S_FETCH;
        end else begin
          nxt = S_TRAP;
        end
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  // Only completed instructions count; TRAP and reset never reach here
  assign retire_evt = (nxt == S_FETCH) &&
                      (state == S_MEMWB || state == S_MEMWR ||
                       state == S_ALUWB || state == S_BRANCH);

  assign bus.pc_write   = cw.pc_write  & ~rst;
  assign bus.pc_src     = cw.pc_src;
  assign bus.ir_write   = cw.ir_write  & ~rst;
  assign bus.adr_src    = cw.adr_src;
  assign bus.mem_read   = cw.mem_read  & ~rst;
  assign bus.MemWrite   = cw.mem_write & ~rst;
  assign bus.RegWrite   = cw.reg_write & ~rst;
  assign bus.alu_src_a  = cw.src_a;
  assign bus.alu_src_b  = cw.src_b;
  assign bus.ALUctrl    = cw.alu_ctrl;
  assign bus.ImmSrc     = cw.imm_src;
  assign bus.result_src = cw.result_src;
  assign bus.state_o    = state;
  assign bus.illegal    = (state == S_TRAP) & ~rst;
  assign bus.retired    = retired_q;

endmodule
